// File: rtl/veerwolf_wb_initiator_pkg.sv
// rtl/veerwolf_wb_initiator_pkg.sv - shared types and constants for the Wishbone initiator
package veerwolf_wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WB_AW_MAX = 32;

    typedef struct packed {
        logic                 we;
        logic [WB_AW_MAX-1:0] adr;
        logic [31:0]          dat;
        logic [3:0]           sel;
    } wb_cmd_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } wb_rsp_t;

    localparam logic [31:0] RSP_ERR_DATA = 32'h0;

endpackage

// File: rtl/veerwolf_wb_timeout.sv
// rtl/veerwolf_wb_timeout.sv - saturating bus-cycle counter with an expiry pulse
module veerwolf_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 9
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TO_W'(TIMEOUT_CYCLES))) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // Expires during the last permitted bus cycle; a zero limit disables it.
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_en &&
                       (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/veerwolf_wb_initiator.sv
// rtl/veerwolf_wb_initiator.sv - single-outstanding Wishbone classic initiator (option: VEERWOLF_WB_INITIATOR_ERR_EN)
module veerwolf_wb_initiator
    import veerwolf_wb_initiator_pkg::*;
#(
    parameter int AW             = 6,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_we,
    input  logic [AW-1:0] i_cmd_adr,
    input  logic [31:0]   i_cmd_dat,
    input  logic [3:0]    i_cmd_sel,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_dat,
    output logic          o_rsp_err,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
`ifdef VEERWOLF_WB_INITIATOR_ERR_EN
    input  logic          i_wb_err,
`endif
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack
);

    state_t  r_state;
    state_t  w_state_next;
    wb_cmd_t r_cmd;
    wb_rsp_t r_rsp;
    logic    r_cyc;
    logic    r_rsp_valid;
    logic    r_cmd_ready;
    logic    w_accept;
    logic    w_done_ok;
    logic    w_done_err;
    logic    w_expired;
    logic    w_bus_err;

`ifdef VEERWOLF_WB_INITIATOR_ERR_EN
    assign w_bus_err = i_wb_err;
`else
    assign w_bus_err = 1'b0;
`endif

    veerwolf_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_accept),
        .i_en      (r_state == BUS),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_ok    = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = BUS;
                end
            end
            BUS: begin
                // ack beats bus error, which beats timeout
                if (i_wb_ack) begin
                    w_done_ok    = 1'b1;
                    w_state_next = RESP;
                end else if (w_bus_err || w_expired) begin
                    w_done_err   = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_rsp       <= '0;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == IDLE);
            if (w_accept) begin
                r_cmd.we  <= i_cmd_we;
                r_cmd.adr <= WB_AW_MAX'(i_cmd_adr);
                r_cmd.dat <= i_cmd_dat;
                r_cmd.sel <= i_cmd_sel;
                r_cyc     <= 1'b1;
            end
            if (w_done_ok) begin
                r_cyc       <= 1'b0;
                r_rsp.dat   <= r_cmd.we ? RSP_ERR_DATA : i_wb_rdt;
                r_rsp.err   <= 1'b0;
                r_rsp_valid <= 1'b1;
            end
            if (w_done_err) begin
                r_cyc       <= 1'b0;
                r_rsp.dat   <= RSP_ERR_DATA;
                r_rsp.err   <= 1'b1;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == RESP) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_dat   = r_rsp.dat;
    assign o_rsp_err   = r_rsp.err;
    assign o_wb_adr    = AW'(r_cmd.adr);
    assign o_wb_dat    = r_cmd.dat;
    assign o_wb_sel    = r_cmd.sel;
    assign o_wb_we     = r_cmd.we;
    assign o_wb_cyc    = r_cyc;
    assign o_wb_stb    = r_cyc;

endmodule

// File: tb/tb_veerwolf_wb_initiator.sv
// tb/tb_veerwolf_wb_initiator.sv - directed self-checking bench for the Wishbone initiator
module tb_veerwolf_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [5:0]  cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [5:0]  wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    veerwolf_wb_initiator #(
        .AW             (6),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_adr   (cmd_adr),
        .i_cmd_dat   (cmd_dat),
        .i_cmd_sel   (cmd_sel),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_dat   (rsp_dat),
        .o_rsp_err   (rsp_err),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .o_wb_we     (wb_we),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
`ifdef VEERWOLF_WB_INITIATOR_ERR_EN
        .i_wb_err    (wb_err),
`endif
        .i_wb_rdt    (wb_rdt),
        .i_wb_ack    (wb_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] rdt, input int ack_at,
                       input int err_at, input int hold, input bit late_ack,
                       output int cyc_n, output int lat, output logic [31:0] rd,
                       output logic re);
        bit got;
        cyc_n = 0;
        lat   = 0;
        got   = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        wb_rdt    = rdt;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wb_cyc) begin
                cyc_n++;
                check("wb_adr", 64'(wb_adr), 64'(adr));
                check("wb_dat", 64'(wb_dat), 64'(dat));
                check("wb_sel", 64'(wb_sel), 64'(sel));
                check("wb_we",  64'(wb_we),  64'(we));
                check("wb_stb", 64'(wb_stb), 64'd1);
                check("cmd_ready_bus", 64'(cmd_ready), 64'd0);
            end
            wb_ack = wb_cyc && (ack_at != 0) && (cyc_n == ack_at);
            wb_err = wb_cyc && (err_at != 0) && (cyc_n == err_at);
            if (rsp_valid) begin
                lat = n;
                got = 1;
                break;
            end
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
        check("rsp_seen", 64'(got), 64'd1);
        rd = rsp_dat;
        re = rsp_err;
        for (int i = 0; i < hold; i++) begin
            wb_ack = late_ack && (i == 0);
            @(negedge clk);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_dat",   64'(rsp_dat),   64'(rd));
            check("hold_err",   64'(rsp_err),   64'(re));
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check("hold_cyc",   64'(wb_cyc),    64'd0);
        end
        wb_ack    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_valid", 64'(rsp_valid), 64'd0);
        check("post_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cn;
        int          lt;
        logic [31:0] rd;
        logic        re;
        bit          seen;

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; wb_rdt = '0; wb_ack = 1'b0; wb_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_dat",   64'(rsp_dat),   64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        check("rst_cyc",       64'(wb_cyc),    64'd0);
        check("rst_stb",       64'(wb_stb),    64'd0);
        check("rst_wb_bus",    {wb_we, wb_sel, wb_adr, wb_dat}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(cmd_ready), 64'd1);

        // write, ack in second cyc cycle
        run(1'b1, 6'h38, 32'h12345678, 4'hF, 32'hFFFF0000, 2, 0, 0, 0, cn, lt, rd, re);
        check("wr_cyc_len", 64'(cn), 64'd2);
        check("wr_latency", 64'(lt), 64'd3);
        check("wr_dat", 64'(rd), 64'd0);
        check("wr_err", 64'(re), 64'd0);

        // read, three wait cycles
        run(1'b0, 6'h04, 32'h0, 4'h3, 32'hA5A50001, 4, 0, 0, 0, cn, lt, rd, re);
        check("rd_cyc_len", 64'(cn), 64'd4);
        check("rd_latency", 64'(lt), 64'd5);
        check("rd_dat", 64'(rd), 64'hA5A50001);
        check("rd_err", 64'(re), 64'd0);

        // read, zero wait, with back-pressure
        run(1'b0, 6'h2C, 32'h0, 4'h1, 32'hDEADBEEF, 1, 0, 5, 0, cn, lt, rd, re);
        check("rd0_cyc_len", 64'(cn), 64'd1);
        check("rd0_latency", 64'(lt), 64'd2);
        check("rd0_dat", 64'(rd), 64'hDEADBEEF);

        // timeout with a late ack during the response phase
        run(1'b0, 6'h10, 32'h0, 4'hF, 32'h55AA55AA, 0, 0, 5, 1, cn, lt, rd, re);
        check("to_cyc_len", 64'(cn), 64'd8);
        check("to_latency", 64'(lt), 64'd9);
        check("to_dat", 64'(rd), 64'd0);
        check("to_err", 64'(re), 64'd1);

`ifdef VEERWOLF_WB_INITIATOR_ERR_EN
        run(1'b0, 6'h08, 32'h0, 4'hF, 32'h0BADF00D, 2, 2, 0, 0, cn, lt, rd, re);
        check("ackerr_dat", 64'(rd), 64'h0BADF00D);
        check("ackerr_err", 64'(re), 64'd0);
        run(1'b0, 6'h0C, 32'h0, 4'hF, 32'h13579BDF, 0, 3, 0, 0, cn, lt, rd, re);
        check("err_cyc_len", 64'(cn), 64'd3);
        check("err_dat", 64'(rd), 64'd0);
        check("err_err", 64'(re), 64'd1);
`endif

        // reset in the middle of a bus cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 6'h20; cmd_dat = 32'hCAFEF00D; cmd_sel = 4'hC;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_cyc", 64'(wb_cyc), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cyc", 64'(wb_cyc), 64'd0);
        check("mid_rst_stb", 64'(wb_stb), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc) seen = 1;
        end
        rsp_ready = 1'b0;
        check("mid_no_rsp", 64'(seen), 64'd0);
        check("mid_ready", 64'(cmd_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/veerwolf_wb_initiator.md
Name: veerwolf_wb_initiator

Overview:
Single-outstanding Wishbone classic initiator. It turns a valid/ready command stream into Wishbone read/write cycles against SoC responders such as the system controller. It sits between a debug/test command source and the peripheral Wishbone bus, and returns read data or a timeout error on a valid/ready response stream.

Parameters:
AW, 6, Wishbone address width (byte address).
TIMEOUT_CYCLES, 256, cycles with cyc asserted before abort; 0 = never time out.
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width; must be at least 1.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid & ready
i_cmd_we  in  1  1 = write, 0 = read
i_cmd_adr  in  AW  byte address
i_cmd_dat  in  32  write data
i_cmd_sel  in  4  byte lane selects
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed when valid & ready
o_rsp_dat  out  32  read data; 0 for writes and errors
o_rsp_err  out  1  1 = transaction aborted by timeout (or bus error)
o_wb_adr  out  AW  Wishbone address
o_wb_dat  out  32  Wishbone write data
o_wb_sel  out  4  Wishbone byte selects
o_wb_we  out  1  Wishbone write enable
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
i_wb_rdt  in  32  Wishbone read data
i_wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_cmd_ready=0, o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0, o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0. State = IDLE. Timeout counter = 0.
- FSM IDLE:
  - o_cmd_ready=1.
  - On accept at edge N: latch adr/dat/sel/we onto the o_wb_* registers, clear the counter, go to BUS. cyc and stb are high from cycle N+1.
- FSM BUS:
  - o_cmd_ready=0. cyc and stb are held high together (classic cycle, no pipelining). o_wb_* are held stable.
  - Counter increments each cycle, saturating at TIMEOUT_CYCLES.
  - If i_wb_ack=1 at an edge: drop cyc/stb next cycle; capture o_rsp_dat = i_wb_rdt for reads, 0 for writes; set o_rsp_err=0; go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: drop cyc/stb; set o_rsp_dat=0, o_rsp_err=1; go to RESP.
  - Ack and timeout at the same edge: ack wins.
- FSM RESP:
  - o_rsp_valid=1; response fields are stable until consumed. o_cmd_ready=0.
  - On o_rsp_valid & i_rsp_ready: clear o_rsp_valid, go to IDLE. o_cmd_ready is 1 the following cycle.
  - Any i_wb_ack arriving outside BUS is ignored.
- Latency against a responder that acks one cycle after cyc:
  - accept at N, cyc at N+1, ack sampled at N+2, o_rsp_valid at N+3.
  - With i_rsp_ready held high, the next accept is at N+4.
- Throughput: at most one transaction outstanding.
- Reset mid-transaction: cyc/stb deassert at the reset edge. Any pending response is discarded and no response is issued.
- Counter width is TO_W; it never wraps.

Optional Feature:
Macro VEERWOLF_WB_INITIATOR_ERR_EN.
- Defined: adds input port i_wb_err (1 bit). In BUS, i_wb_err=1 ends the cycle exactly like a timeout (o_rsp_err=1, o_rsp_dat=0).
  - Priority at the same edge: ack > err > timeout.
- Undefined: the port does not exist; only a timeout produces o_rsp_err=1.

Decomposition:
- Package veerwolf_wb_initiator_pkg:
  - state enum {IDLE, BUS, RESP}
  - struct wb_cmd_t {we, adr, dat, sel}
  - struct wb_rsp_t {dat, err}
  - localparam RSP_ERR_DATA = 32'h0
- Sub-module veerwolf_wb_timeout: saturating cycle counter.
  - Inputs: clear, count-enable.
  - Output: expired pulse; tied to 0 when TIMEOUT_CYCLES=0.

Test Plan:
- Write, responder acks 1 cycle after cyc:
  - stimulus: cmd we=1, adr=0x38, dat=0x12345678, sel=4'hF.
  - required: o_wb_* equal those values while cyc=1; cyc high exactly 2 cycles; rsp_valid 3 cycles after accept with dat=0, err=0.
- Read, responder returns 0xA5A5_0001 after 3 wait cycles:
  - required: o_rsp_dat=0xA5A5_0001, err=0; cyc high 4 cycles.
- Timeout with TIMEOUT_CYCLES=8 and no ack:
  - required: cyc high exactly 8 cycles, then rsp err=1, dat=0.
  - A late ack one cycle after cyc drops is ignored.
- Back-pressure: hold i_rsp_ready=0 for 5 cycles.
  - required: rsp fields stable and o_cmd_ready=0 throughout.
  - A new command is accepted only the cycle after the handshake.
- Reset mid-BUS: assert i_rst while cyc=1.
  - required: cyc/stb=0 next cycle, no rsp_valid ever, o_cmd_ready=1 after reset deasserts.
- With VEERWOLF_WB_INITIATOR_ERR_EN: i_wb_err and i_wb_ack high at the same edge.
  - required: err=0 and read data captured.
  - A separate cycle with err alone gives err=1.
